systolic_feeder: RTL
====================

# systolic_feeder

Edge feeder for the weight-stationary systolic array: drives the top-edge weight/load lines and the left-edge activation lines consumed by the `mac_unit` grid. It loads one N×N weight tile via a valid/ready stream, then streams activation vectors into the array with the diagonal skew the PEs require (row r delayed r cycles). It then drains the pipeline and signals completion. It sits between the tile buffers and the array, and is the transmitting end of the array's wi/L/ai interface.

## Interface
- `N`, 4, array dimension (rows = columns), 2..16
- `DW`, 8, signed element width of weights and activations
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin one tile operation; sampled only in IDLE
- `k_len`  in  8  activation vectors to stream; latched on accepted start
- `reuse_w`  in  1  skip weight load; used only with FEEDER_REUSE_W_EN
- `w_valid`  in  1  weight row beat valid
- `w_ready`  out  1  weight row beat accepted when both high
- `w_data`  in  N*DW  one weight row, column c at bits [c*DW +: DW]
- `a_valid`  in  1  activation vector beat valid
- `a_ready`  out  1  activation beat accepted when both high
- `a_data`  in  N*DW  one activation vector, row r at bits [r*DW +: DW]
- `L`  out  1  weight-load enable broadcast to array
- `wo_edge`  out  N*DW  weights to top of each column
- `ao_edge`  out  N*DW  skewed activations to left of each row
- `ao_vld`  out  N  per-row activation valid, skewed with `ao_edge`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: if `start` is high, latch `k_len` and go to LOAD_W (or STREAM if reuse is enabled and `reuse_w` is high). `start` in any other state is ignored.
- LOAD_W:
  - `w_ready`=1. Beat counter counts accepted beats 0..N-1.
  - The Nth accepted beat moves to STREAM; if latched `k_len`=0, it moves straight to IDLE with `done`.
  - Beat order: first beat ends in the bottom PE row, last beat in the top row.
- STREAM:
  - `a_ready`=1. Counts accepted beats up to `k_len`.
  - A cycle with no accepted beat injects a bubble: zero data and `ao_vld`=0 into the skew line.
  - The `k_len`th accepted beat moves to DRAIN.
- DRAIN:
  - `a_ready`=0. Zeros with valid=0 enter the skew line.
  - Lasts exactly 2N-1 cycles, then IDLE with `done`.
- Skew: row r has an r-stage shift register after the common output register. Data and valid shift together every cycle, including bubbles.
- Weights: `wo_edge`=`w_data` of the accepted beat with `L`=1. Otherwise `wo_edge`=0 and `L`=0.
- Widths: pure data movement, no arithmetic; all values passed bit-exact.
- `rst` in any state: IDLE, counters cleared, skew registers cleared, any in-flight tile abandoned.

## Timing
- Reset values: `w_ready`=0, `a_ready`=0, `L`=0, `wo_edge`=0, `ao_edge`=0, `ao_vld`=0, `busy`=0, `done`=0.
- `busy` is high from the cycle after accepted `start` through the last DRAIN cycle (or the last LOAD_W cycle when `k_len`=0).
- `w_ready` and `a_ready` are pure functions of state; they never depend combinationally on `w_valid`/`a_valid`.
- Weight beat accepted at edge t: `L`=1 and `wo_edge` valid during cycle t+1 only.
- Activation accepted at edge t: row r sees it on `ao_edge`/`ao_vld[r]` during cycle t+1+r.
- First STREAM cycle immediately follows the edge accepting the Nth weight beat.
- `done` is high for the single cycle after the final DRAIN cycle; `busy`=0 in that cycle. A new `start` is accepted in that same cycle.

## Configuration
- `FEEDER_REUSE_W_EN` defined: `start` with `reuse_w`=1 skips LOAD_W and keeps the weights already resident in the array. `L` stays 0 for the whole operation.
- `FEEDER_REUSE_W_EN` undefined: `reuse_w` is ignored; every operation runs LOAD_W.

## Test plan
- Reset mid-STREAM, N=4: assert `rst` after 2 activation beats. Next cycle all outputs are 0 and state is IDLE; a fresh `start` works normally.
- Weight load, N=4: rows 1,2,3,4 back-to-back. `L`=1 for exactly 4 consecutive cycles with `wo_edge` matching each row one cycle after acceptance; `w_ready` drops after the 4th beat.
- Skew, N=4, `k_len`=2: vectors {1,2,3,4},{5,6,7,8} accepted at edges t, t+1. Row 3 shows 4 at cycle t+4 and 8 at cycle t+5; row 0 shows 1 at cycle t+1.
- Bubble: `a_valid` low for one cycle between beats. Every row sees exactly one zero/`ao_vld`=0 gap at the same relative position.
- Completion, N=4, `k_len`=3: DRAIN lasts 7 cycles; `done` pulses once; `start` asserted while busy has no effect.
- `k_len`=0, plus (with `FEEDER_REUSE_W_EN`) `reuse_w`=1:
  - `k_len`=0: `done` arrives the cycle after the 4th weight beat.
  - `reuse_w`=1: `L` never rises and streaming begins the cycle after `start`.

Source files
------------

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder
// ----------------------------------------------------------------------------
// Edge feeder for the weight-stationary systolic array. It loads one N x N
// weight tile row by row onto the top edge (wo_edge with the L broadcast).
// It then streams activation vectors onto the left edge with a diagonal skew:
// row r is delayed r cycles. Finally it drains the skew line and pulses done.
//
// Optional feature macro: FEEDER_REUSE_W_EN
//   defined   : start with reuse_w=1 skips the weight load and goes straight
//               to streaming; L stays low for the whole operation.
//   undefined : reuse_w is ignored and every operation loads weights.
//
// Parameters
//   N   array dimension (rows = columns), 2..16
//   DW  element width of weights and activations (bit-exact pass-through)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   begin one tile operation (sampled only when idle)
//   k_len    in   number of activation vectors, latched on accepted start
//   reuse_w  in   skip weight load (only with FEEDER_REUSE_W_EN)
//   w_valid  in   weight row beat valid
//   w_ready  out  weight row beat accepted when w_valid & w_ready
//   w_data   in   weight row, column c at [c*DW +: DW]
//   a_valid  in   activation beat valid
//   a_ready  out  activation beat accepted when a_valid & a_ready
//   a_data   in   activation vector, row r at [r*DW +: DW]
//   L        out  weight-load enable broadcast to the array
//   wo_edge  out  weights to the top of each column
//   ao_edge  out  skewed activations to the left of each row
//   ao_vld   out  per-row activation valid, skewed with ao_edge
//   busy     out  operation in progress
//   done     out  one-cycle completion pulse
// ============================================================================
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        k_len,
    input  logic              reuse_w,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [N*DW-1:0]   w_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [N*DW-1:0]   a_data,
    output logic              L,
    output logic [N*DW-1:0]   wo_edge,
    output logic [N*DW-1:0]   ao_edge,
    output logic [N-1:0]      ao_vld,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Terminal counts: N weight beats, 2N-1 drain cycles.
    localparam logic [7:0] LP_W_LAST = 8'(N - 1);
    localparam logic [7:0] LP_D_LAST = 8'(2 * N - 2);

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_klen;
    logic       r_done;

    logic       w_reuse;
    logic       w_w_acc;
    logic       w_a_acc;

`ifdef FEEDER_REUSE_W_EN
    assign w_reuse = reuse_w;
`else
    logic w_unused_reuse;
    assign w_unused_reuse = reuse_w;
    assign w_reuse        = 1'b0;
`endif

    // Handshake readies depend on state only, never on the valids.
    assign w_ready = (r_state == ST_LOAD_W);
    assign a_ready = (r_state == ST_STREAM);
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

    assign w_w_acc = w_ready & w_valid;
    assign w_a_acc = a_ready & a_valid;

    // ------------------------------------------------------------------
    // Control: operation sequencing and beat / drain counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_klen  <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (start) begin
                        r_klen <= k_len;
                        if (w_reuse) begin
                            // Nothing to stream: go through an empty drain so
                            // the operation still completes with done.
                            r_state <= (k_len == 8'd0) ? ST_DRAIN : ST_STREAM;
                        end else begin
                            r_state <= ST_LOAD_W;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_w_acc) begin
                        if (r_cnt == LP_W_LAST) begin
                            r_cnt <= 8'd0;
                            if (r_klen == 8'd0) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_STREAM;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_a_acc) begin
                        if (r_cnt == r_klen - 8'd1) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == LP_D_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: common output registers for the weight and activation edges
    // ------------------------------------------------------------------
    logic              r_l_p0;
    logic [N*DW-1:0]   r_wo_p0;
    logic [N*DW-1:0]   r_adat_p0;
    logic              r_avld_p0;

    // The edge outputs must read as zero after reset, so the data
    // registers are cleared together with the control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l_p0    <= 1'b0;
            r_wo_p0   <= '0;
            r_adat_p0 <= '0;
            r_avld_p0 <= 1'b0;
        end else begin
            r_l_p0    <= w_w_acc;
            r_wo_p0   <= w_w_acc ? w_data : '0;
            // Any cycle without an accepted beat injects a zero bubble.
            r_adat_p0 <= w_a_acc ? a_data : '0;
            r_avld_p0 <= w_a_acc;
        end
    end

    assign L       = r_l_p0;
    assign wo_edge = r_wo_p0;

    // ------------------------------------------------------------------
    // Stages p1..pN-1: per-row skew shift registers (row r is r deep)
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N; r++) begin : gen_row
        if (r == 0) begin : gen_direct
            assign ao_edge[DW-1:0] = r_adat_p0[DW-1:0];
            assign ao_vld[0]       = r_avld_p0;
        end else begin : gen_shift
            logic [DW-1:0] r_dat_pk [0:r-1];
            logic          r_vld_pk [0:r-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) begin
                        r_dat_pk[k] <= '0;
                        r_vld_pk[k] <= 1'b0;
                    end
                end else begin
                    r_dat_pk[0] <= r_adat_p0[r*DW +: DW];
                    r_vld_pk[0] <= r_avld_p0;
                    for (int k = 1; k < r; k++) begin
                        r_dat_pk[k] <= r_dat_pk[k-1];
                        r_vld_pk[k] <= r_vld_pk[k-1];
                    end
                end
            end

            assign ao_edge[r*DW +: DW] = r_dat_pk[r-1];
            assign ao_vld[r]           = r_vld_pk[r-1];
        end
    end

endmodule
